rv32i_calc_mailbox: RTL and testbench

// - Parametrised host mailbox between an external requester and an rv32i_cpu-class core.

---
 rtl/rv32i_calc_mailbox_if.sv | 26 ++
 rtl/rv32i_calc_mailbox.sv | 154 +++++++++++++++
 tb/tb_rv32i_calc_mailbox.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_calc_mailbox_if.sv
// Host-side mailbox bus: request operands in and result out, each with a
// valid/ready handshake. The mailbox takes the slave modport and the
// requester takes the master modport.
`timescale 1ns/1ps
interface rv32i_calc_mailbox_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_ARGS = 2
);
   logic                       req_valid;
   logic                       req_ready;
   logic [NUM_ARGS*DATA_W-1:0] req_args;
   logic                       res_valid;
   logic                       res_ready;
   logic [DATA_W-1:0]          res_data;
   logic                       res_timeout;

   modport slave (
      input  req_valid, req_args, res_ready,
      output req_ready, res_valid, res_data, res_timeout
   );

   modport master (
      output req_valid, req_args, res_ready,
      input  req_ready, res_valid, res_data, res_timeout
   );
endinterface

// File: rtl/rv32i_calc_mailbox.sv
// Host mailbox for an rv32i-class core. It takes NUM_ARGS operands, preloads
// them into core registers, releases the core from reset, and watches the
// core's register write port for the completion write. It then returns the
// captured result register, or flags a timeout.
// Optional feature macro: RV32I_MBOX_CYCLE_CNT_EN (adds o_res_cycles, the
// number of RUN cycles, saturating).
`timescale 1ns/1ps
module rv32i_calc_mailbox #(
   parameter int DATA_W       = 32,
   parameter int NUM_ARGS     = 2,
   parameter int ARG_BASE_REG = 10,
   parameter int RES_REG      = 10,
   parameter int DONE_REG     = 31,
   parameter int TIMEOUT_CYC  = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rv32i_calc_mailbox_if.slave  bus,
   output logic                 o_core_rst_n,
   output logic                 o_arg_we,
   output logic [4:0]           o_arg_addr,
   output logic [DATA_W-1:0]    o_arg_data,
   input  logic                 i_snoop_we,
   input  logic [4:0]           i_snoop_addr,
   input  logic [DATA_W-1:0]    i_snoop_data
`ifdef RV32I_MBOX_CYCLE_CNT_EN
   ,
   output logic [31:0]          o_res_cycles
`endif
);

   if (NUM_ARGS < 1 || NUM_ARGS > 8) begin : g_bad_num_args
      $error("rv32i_calc_mailbox: NUM_ARGS must be 1..8");
   end
   if (ARG_BASE_REG + NUM_ARGS - 1 > 31) begin : g_bad_arg_base
      $error("rv32i_calc_mailbox: operand registers exceed x31");
   end

   localparam int IW = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
   // The timer only has to reach TIMEOUT_CYC-1, so this width is enough
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ARGS - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [4:0]    BASE_A   = 5'(ARG_BASE_REG);
   localparam logic [4:0]    RES_A    = 5'(RES_REG);
   localparam logic [4:0]    DONE_A   = 5'(DONE_REG);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_args [NUM_ARGS];
   logic [IW-1:0]     r_idx;
   logic [TW-1:0]     r_timer;
   logic [DATA_W-1:0] r_shadow;
   logic [DATA_W-1:0] r_res_data;
   logic              r_res_timeout;

   logic w_accept, w_load_last, w_snoop_ok, w_res_hit, w_done_hit, w_timeout;

   assign w_accept    = bus.req_valid && (r_state == S_IDLE);
   assign w_load_last = (r_state == S_LOAD) && (r_idx == LAST_IDX);
   // Writes to x0 never change architectural state, so they are never snooped
   assign w_snoop_ok  = (r_state == S_RUN) && i_snoop_we && (i_snoop_addr != 5'd0);
   assign w_res_hit   = w_snoop_ok && (i_snoop_addr == RES_A);
   assign w_done_hit  = w_snoop_ok && (i_snoop_addr == DONE_A);
   assign w_timeout   = (r_state == S_RUN) && (TIMEOUT_CYC != 0) && (r_timer == TO_LAST);

   assign o_arg_addr      = BASE_A + 5'(r_idx);
   assign o_arg_data      = r_args[r_idx];
   assign bus.res_data    = r_res_data;
   assign bus.res_timeout = r_res_timeout;

   // State register; an async reset also pulls the core back into reset at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and the state-decoded handshake/core controls
   always_comb begin
      w_state_nxt   = r_state;
      bus.req_ready = 1'b0;
      bus.res_valid = 1'b0;
      o_arg_we      = 1'b0;
      o_core_rst_n  = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            o_arg_we = 1'b1;
            if (r_idx == LAST_IDX) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            o_core_rst_n = 1'b1;
            if (w_done_hit || w_timeout) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand latch; pure data, always loaded before use so it needs no reset
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < NUM_ARGS; i++) r_args[i] <= bus.req_args[i*DATA_W +: DATA_W];
      end
   end

   // Shadow copy of the result register, cleared as the core is released
   always_ff @(posedge clk) begin
      if (w_load_last)    r_shadow <= '0;
      else if (w_res_hit) r_shadow <= i_snoop_data;
   end

   // Preload index, run timer and captured result; completion beats timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx         <= '0;
         r_timer       <= '0;
         r_res_data    <= '0;
         r_res_timeout <= 1'b0;
      end else begin
         if (w_accept)                                   r_idx <= '0;
         else if ((r_state == S_LOAD) && !w_load_last)   r_idx <= r_idx + 1'b1;
         if (w_load_last)            r_timer <= '0;
         else if (r_state == S_RUN)  r_timer <= r_timer + 1'b1;
         if (w_done_hit) begin
            r_res_data    <= w_res_hit ? i_snoop_data : r_shadow;
            r_res_timeout <= 1'b0;
         end else if (w_timeout) begin
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
         end
      end
   end

`ifdef RV32I_MBOX_CYCLE_CNT_EN
   logic [31:0] r_cycles;
   assign o_res_cycles = r_cycles;

   // Saturating count of RUN cycles, including the cycle that ends the run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      r_cycles <= '0;
      else if (w_load_last)                            r_cycles <= '0;
      else if ((r_state == S_RUN) && (r_cycles != '1)) r_cycles <= r_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_rv32i_calc_mailbox.sv
// Directed bench for rv32i_calc_mailbox. The bench plays the core: it drives
// snoop writes and watches the preload port. u_dut uses TIMEOUT_CYC=16.
// u_dut2 uses RES_REG==DONE_REG==10.
`timescale 1ns/1ps
module tb_rv32i_calc_mailbox;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   rv32i_calc_mailbox_if #(.DATA_W(32), .NUM_ARGS(2)) m1 ();
   rv32i_calc_mailbox_if #(.DATA_W(32), .NUM_ARGS(2)) m2 ();

   logic        core_rst_n, arg_we, snoop_we;
   logic [4:0]  arg_addr, snoop_addr;
   logic [31:0] arg_data, snoop_data;
   logic        core_rst_n2, arg_we2, snoop_we2;
   logic [4:0]  arg_addr2, snoop_addr2;
   logic [31:0] arg_data2, snoop_data2;
`ifdef RV32I_MBOX_CYCLE_CNT_EN
   logic [31:0] res_cycles, res_cycles2;
`endif

   rv32i_calc_mailbox #(.DATA_W(32), .NUM_ARGS(2), .ARG_BASE_REG(10), .RES_REG(10),
                        .DONE_REG(31), .TIMEOUT_CYC(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(m1),
      .o_core_rst_n(core_rst_n), .o_arg_we(arg_we), .o_arg_addr(arg_addr), .o_arg_data(arg_data),
      .i_snoop_we(snoop_we), .i_snoop_addr(snoop_addr), .i_snoop_data(snoop_data)
`ifdef RV32I_MBOX_CYCLE_CNT_EN
      , .o_res_cycles(res_cycles)
`endif
   );

   rv32i_calc_mailbox #(.DATA_W(32), .NUM_ARGS(2), .ARG_BASE_REG(10), .RES_REG(10),
                        .DONE_REG(10), .TIMEOUT_CYC(16)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(m2),
      .o_core_rst_n(core_rst_n2), .o_arg_we(arg_we2), .o_arg_addr(arg_addr2), .o_arg_data(arg_data2),
      .i_snoop_we(snoop_we2), .i_snoop_addr(snoop_addr2), .i_snoop_data(snoop_data2)
`ifdef RV32I_MBOX_CYCLE_CNT_EN
      , .o_res_cycles(res_cycles2)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a request on u_dut and step to the first RUN cycle
   task automatic start_run(input logic [31:0] a0, input logic [31:0] a1);
      m1.req_args  = {a1, a0};
      m1.req_valid = 1'b1;
      tick();
      m1.req_valid = 1'b0;
      tick();
      tick();
   endtask

   // One core register write on u_dut, held for one cycle
   task automatic snoop(input logic [4:0] a, input logic [31:0] d);
      snoop_we = 1'b1; snoop_addr = a; snoop_data = d;
      tick();
      snoop_we = 1'b0; snoop_addr = 5'd0; snoop_data = 32'd0;
   endtask

   task automatic consume();
      m1.res_ready = 1'b1;
      tick();
      m1.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (m1.res_valid !== 1'b0 || m1.res_data !== 32'd0 || m1.res_timeout !== 1'b0 ||
          core_rst_n !== 1'b0 || arg_we !== 1'b0 || m1.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: valid=%b data=%0d to=%b core_rst_n=%b arg_we=%b req_ready=%b, required 0 0 0 0 0 1",
                  m1.res_valid, m1.res_data, m1.res_timeout, core_rst_n, arg_we, m1.req_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      m1.req_args  = {32'd18, 32'd48};
      m1.req_valid = 1'b1;
      tick();
      m1.req_valid = 1'b0;
      checks++;
      if (arg_we !== 1'b1 || arg_addr !== 5'd10 || arg_data !== 32'd48 || core_rst_n !== 1'b0 || m1.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_load0: we=%b addr=%0d data=%0d core_rst_n=%b ready=%b, required 1 10 48 0 0",
                  arg_we, arg_addr, arg_data, core_rst_n, m1.req_ready);
      end
      tick();
      checks++;
      if (arg_we !== 1'b1 || arg_addr !== 5'd11 || arg_data !== 32'd18 || core_rst_n !== 1'b0) begin
         failures++;
         $display("FAIL basic_load1: we=%b addr=%0d data=%0d core_rst_n=%b, required 1 11 18 0",
                  arg_we, arg_addr, arg_data, core_rst_n);
      end
      tick();
      checks++;
      if (arg_we !== 1'b0 || core_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL basic_release: we=%b core_rst_n=%b, required 0 1", arg_we, core_rst_n);
      end
      snoop(5'd10, 32'd6);
      snoop(5'd31, 32'd1);
      checks++;
      if (m1.res_valid !== 1'b1 || m1.res_data !== 32'd6 || m1.res_timeout !== 1'b0 || core_rst_n !== 1'b0) begin
         failures++;
         $display("FAIL basic_result: valid=%b data=%0d to=%b core_rst_n=%b, required 1 6 0 0",
                  m1.res_valid, m1.res_data, m1.res_timeout, core_rst_n);
      end
      consume();
      checks++;
      if (m1.res_valid !== 1'b0 || m1.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_idle: valid=%b req_ready=%b, required 0 1", m1.res_valid, m1.req_ready);
      end
   endtask

   task automatic test_timeout();
      start_run(32'd1, 32'd2);
      repeat (15) tick();
      checks++;
      if (m1.res_valid !== 1'b0 || core_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL timeout_run16: valid=%b core_rst_n=%b, required 0 1", m1.res_valid, core_rst_n);
      end
      tick();
      checks++;
      if (m1.res_valid !== 1'b1 || m1.res_data !== 32'd0 || m1.res_timeout !== 1'b1 || core_rst_n !== 1'b0) begin
         failures++;
         $display("FAIL timeout_result: valid=%b data=%0d to=%b core_rst_n=%b, required 1 0 1 0",
                  m1.res_valid, m1.res_data, m1.res_timeout, core_rst_n);
      end
      consume();
   endtask

   task automatic test_backpressure();
      int bad;
      bad = 0;
      start_run(32'd5, 32'd7);
      snoop(5'd10, 32'd42);
      snoop(5'd31, 32'd1);
      m1.req_args  = {32'd3, 32'd4};
      m1.req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         snoop_we   = 1'b1;
         snoop_addr = (i % 2 == 0) ? 5'd10 : 5'd31;
         snoop_data = 32'd99;
         if (m1.res_valid !== 1'b1 || m1.res_data !== 32'd42 || m1.res_timeout !== 1'b0 || m1.req_ready !== 1'b0) bad++;
         tick();
      end
      snoop_we = 1'b0;
      m1.req_valid = 1'b0;
      checks++;
      if (bad != 0 || m1.res_data !== 32'd42 || m1.res_valid !== 1'b1) begin
         failures++;
         $display("FAIL backpressure_hold: bad_cycles=%0d data=%0d valid=%b, required 0 42 1", bad, m1.res_data, m1.res_valid);
      end
      consume();
      checks++;
      if (m1.res_valid !== 1'b0 || m1.req_ready !== 1'b1 || arg_we !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release: valid=%b req_ready=%b arg_we=%b, required 0 1 0",
                  m1.res_valid, m1.req_ready, arg_we);
      end
   endtask

   task automatic test_done_on_timeout();
      start_run(32'd8, 32'd9);
      snoop(5'd0, 32'd123);
      snoop(5'd10, 32'd55);
      repeat (13) tick();
      snoop(5'd31, 32'd1);
      checks++;
      if (m1.res_valid !== 1'b1 || m1.res_timeout !== 1'b0 || m1.res_data !== 32'd55) begin
         failures++;
         $display("FAIL done_on_timeout: valid=%b to=%b data=%0d, required 1 0 55",
                  m1.res_valid, m1.res_timeout, m1.res_data);
      end
      consume();
   endtask

   task automatic test_same_reg();
      m2.req_args  = {32'd2, 32'd1};
      m2.req_valid = 1'b1;
      tick();
      m2.req_valid = 1'b0;
      tick();
      tick();
      snoop_we2 = 1'b1; snoop_addr2 = 5'd10; snoop_data2 = 32'd7;
      tick();
      snoop_we2 = 1'b0;
      checks++;
      if (m2.res_valid !== 1'b1 || m2.res_data !== 32'd7 || m2.res_timeout !== 1'b0) begin
         failures++;
         $display("FAIL same_reg_result: valid=%b data=%0d to=%b, required 1 7 0",
                  m2.res_valid, m2.res_data, m2.res_timeout);
      end
      m2.res_ready = 1'b1;
      tick();
      m2.res_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      start_run(32'd1, 32'd2);
      snoop(5'd10, 32'd77);
      rst_n = 1'b0;
      #1;
      checks++;
      if (core_rst_n !== 1'b0 || m1.res_valid !== 1'b0 || m1.req_ready !== 1'b1 || m1.res_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid_run: core_rst_n=%b valid=%b req_ready=%b data=%0d, required 0 0 1 0",
                  core_rst_n, m1.res_valid, m1.req_ready, m1.res_data);
      end
      tick();
      rst_n = 1'b1;
      tick();
      start_run(32'd9, 32'd6);
      snoop(5'd10, 32'd3);
      snoop(5'd31, 32'd1);
      checks++;
      if (m1.res_valid !== 1'b1 || m1.res_data !== 32'd3 || m1.res_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_rerun: valid=%b data=%0d to=%b, required 1 3 0",
                  m1.res_valid, m1.res_data, m1.res_timeout);
      end
      consume();
   endtask

`ifdef RV32I_MBOX_CYCLE_CNT_EN
   task automatic test_cycles();
      start_run(32'd4, 32'd4);
      repeat (4) tick();
      snoop(5'd31, 32'd1);
      checks++;
      if (m1.res_valid !== 1'b1 || res_cycles !== 32'd5) begin
         failures++;
         $display("FAIL cycle_count: valid=%b cycles=%0d, required 1 5", m1.res_valid, res_cycles);
      end
      consume();
   endtask
`endif

   initial begin
      m1.req_valid = 1'b0; m1.req_args = '0; m1.res_ready = 1'b0;
      m2.req_valid = 1'b0; m2.req_args = '0; m2.res_ready = 1'b0;
      snoop_we = 1'b0;  snoop_addr = 5'd0;  snoop_data = 32'd0;
      snoop_we2 = 1'b0; snoop_addr2 = 5'd0; snoop_data2 = 32'd0;
      test_reset();
      test_basic();
      test_timeout();
      test_backpressure();
      test_done_on_timeout();
      test_same_reg();
      test_reset_mid_run();
`ifdef RV32I_MBOX_CYCLE_CNT_EN
      test_cycles();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
